// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register and write-back formatter for the MIPS32 core.
// Latency: one cycle MEM->WB; load data is formatted combinationally from the RAM word.
// Backpressure: stall[4]/stall[5] hold or bubble the stage; flush overrides every stall.
module mem_wb_stage #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [5:0]        stall,
    input  logic              flush,
    input  logic [REG_AW-1:0] mem_wd,
    input  logic              mem_wreg,
    input  logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_load,
    input  logic [2:0]        mem_load_op,
    input  logic [1:0]        mem_addr_lo,
    input  logic              mem_whilo,
    input  logic [DATA_W-1:0] mem_hi,
    input  logic [DATA_W-1:0] mem_lo,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic [REG_AW-1:0] wb_wd,
    output logic              wb_wreg,
    output logic [DATA_W-1:0] wb_wdata,
    output logic              wb_whilo,
    output logic [DATA_W-1:0] wb_hi,
    output logic [DATA_W-1:0] wb_lo,
    output logic              wb_is_load,
    output logic              wb_misalign
);

    localparam logic [2:0] OP_LB  = 3'b001;
    localparam logic [2:0] OP_LBU = 3'b010;
    localparam logic [2:0] OP_LH  = 3'b011;
    localparam logic [2:0] OP_LHU = 3'b100;

    logic [DATA_W-1:0] wdata_q;
    logic              load_q;
    logic [2:0]        op_q;
    logic [1:0]        alo_q;
    logic              held_q;
    logic [DATA_W-1:0] hold_q;

    logic stall_unused;
    assign stall_unused = ^stall[3:0];

    logic in_half, in_byte, in_mis;
    assign in_half = (mem_load_op == OP_LH) || (mem_load_op == OP_LHU);
    assign in_byte = (mem_load_op == OP_LB) || (mem_load_op == OP_LBU);
    assign in_mis  = mem_load && ((in_half && mem_addr_lo[0]) ||
                                  (!in_half && !in_byte && (mem_addr_lo != 2'b00)));

    always_ff @(posedge clk) begin
        if (!rst || flush || (stall[4] && !stall[5])) begin
            wb_wd       <= '0;
            wb_wreg     <= 1'b0;
            wdata_q     <= '0;
            load_q      <= 1'b0;
            op_q        <= '0;
            alo_q       <= '0;
            wb_whilo    <= 1'b0;
            wb_hi       <= '0;
            wb_lo       <= '0;
            wb_misalign <= 1'b0;
            held_q      <= 1'b0;
            hold_q      <= '0;
        end else if (!stall[4]) begin
            wb_wd       <= mem_wd;
            wb_wreg     <= mem_wreg && !in_mis;
            wdata_q     <= mem_wdata;
            load_q      <= mem_load;
            op_q        <= mem_load_op;
            alo_q       <= mem_addr_lo;
            wb_whilo    <= mem_whilo;
            wb_hi       <= mem_hi;
            wb_lo       <= mem_lo;
            wb_misalign <= in_mis;
            held_q      <= 1'b0;
        end else if (load_q && !held_q) begin
            // WB stalled: the RAM word is only valid for one cycle, so keep a copy
            hold_q <= ram_rdata;
            held_q <= 1'b1;
        end
    end

    logic [DATA_W-1:0] src;
    logic [7:0]        sel_b;
    logic [15:0]       sel_h;

    always_comb begin
        src = held_q ? hold_q : ram_rdata;
        case (alo_q)
            2'b00:   sel_b = src[DATA_W-1 -: 8];
            2'b01:   sel_b = src[DATA_W-9 -: 8];
            2'b10:   sel_b = src[15:8];
            default: sel_b = src[7:0];
        endcase
        sel_h = alo_q[1] ? src[15:0] : src[DATA_W-1 -: 16];

        if (!load_q) begin
            wb_wdata = wdata_q;
        end else if (wb_misalign) begin
            wb_wdata = '0;
        end else begin
            case (op_q)
                OP_LB:   wb_wdata = {{(DATA_W-8){sel_b[7]}}, sel_b};
                OP_LBU:  wb_wdata = {{(DATA_W-8){1'b0}}, sel_b};
                OP_LH:   wb_wdata = {{(DATA_W-16){sel_h[15]}}, sel_h};
                OP_LHU:  wb_wdata = {{(DATA_W-16){1'b0}}, sel_h};
                default: wb_wdata = src;
            endcase
        end
    end

    assign wb_is_load = load_q && !wb_misalign;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed bench for mem_wb_stage: stimulus pushes expected WB state into a queue,
// a negedge monitor pops and compares each entry in the cycle it is due.
module tb_mem_wb_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  stall;
    logic        flush;
    logic [4:0]  mem_wd;
    logic        mem_wreg;
    logic [31:0] mem_wdata;
    logic        mem_load;
    logic [2:0]  mem_load_op;
    logic [1:0]  mem_addr_lo;
    logic        mem_whilo;
    logic [31:0] mem_hi;
    logic [31:0] mem_lo;
    logic [31:0] ram_rdata;
    logic [4:0]  wb_wd;
    logic        wb_wreg;
    logic [31:0] wb_wdata;
    logic        wb_whilo;
    logic [31:0] wb_hi;
    logic [31:0] wb_lo;
    logic        wb_is_load;
    logic        wb_misalign;

    mem_wb_stage #(.DATA_W(32), .REG_AW(5)) dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .mem_wd(mem_wd), .mem_wreg(mem_wreg), .mem_wdata(mem_wdata),
        .mem_load(mem_load), .mem_load_op(mem_load_op), .mem_addr_lo(mem_addr_lo),
        .mem_whilo(mem_whilo), .mem_hi(mem_hi), .mem_lo(mem_lo),
        .ram_rdata(ram_rdata),
        .wb_wd(wb_wd), .wb_wreg(wb_wreg), .wb_wdata(wb_wdata),
        .wb_whilo(wb_whilo), .wb_hi(wb_hi), .wb_lo(wb_lo),
        .wb_is_load(wb_is_load), .wb_misalign(wb_misalign)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        int           cyc;
        logic [104:0] v;
    } exp_t;

    exp_t  expq[$];
    string nameq[$];
    int    cyc = 0;
    int    checks = 0;
    int    errors = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // {wd, wreg, wdata, whilo, hi, lo, is_load, misalign}
    always @(negedge clk) begin
        logic [104:0] act;
        act = {wb_wd, wb_wreg, wb_wdata, wb_whilo, wb_hi, wb_lo, wb_is_load, wb_misalign};
        while (expq.size() > 0 && expq[0].cyc <= cyc) begin
            exp_t  e;
            string n;
            e = expq.pop_front();
            n = nameq.pop_front();
            checks = checks + 1;
            if (e.cyc != cyc) begin
                errors = errors + 1;
                $display("FAIL %s: expected at cycle %0d, monitor reached it at cycle %0d", n, e.cyc, cyc);
            end else if (act !== e.v) begin
                errors = errors + 1;
                $display("FAIL %s: got %h, expected %h", n, act, e.v);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    task automatic drive(input logic [4:0] wd, input logic wreg, input logic [31:0] wdata,
                         input logic load, input logic [2:0] op, input logic [1:0] alo,
                         input logic whilo, input logic [31:0] hi, input logic [31:0] lo);
        mem_wd = wd; mem_wreg = wreg; mem_wdata = wdata;
        mem_load = load; mem_load_op = op; mem_addr_lo = alo;
        mem_whilo = whilo; mem_hi = hi; mem_lo = lo;
    endtask

    // expectation for the WB state visible in the next cycle
    task automatic ex(input string n, input logic [4:0] wd, input logic wreg,
                      input logic [31:0] wdata, input logic whilo, input logic [31:0] hi,
                      input logic [31:0] lo, input logic isl, input logic mis);
        exp_t e;
        e.cyc = cyc + 1;
        e.v   = {wd, wreg, wdata, whilo, hi, lo, isl, mis};
        expq.push_back(e);
        nameq.push_back(n);
    endtask

    initial begin
        rst = 1'b0; stall = 6'b0; flush = 1'b0; ram_rdata = 32'h0;
        drive(5'd7, 1'b1, 32'h55AA55AA, 1'b0, 3'b000, 2'b00, 1'b1, 32'h1, 32'h2);
        ex("reset_c1", 5'd0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        tick();
        ex("reset_c2", 5'd0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        tick();

        rst = 1'b1;
        drive(5'd3, 1'b1, 32'h12345678, 1'b0, 3'b000, 2'b00, 1'b0, 32'h0, 32'h0);
        ex("alu_op", 5'd3, 1'b1, 32'h12345678, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        tick();

        ram_rdata = 32'h80FF7F01;
        drive(5'd5, 1'b1, 32'h0, 1'b1, 3'b001, 2'b00, 1'b0, 32'h0, 32'h0);
        ex("lb_00", 5'd5, 1'b1, 32'hFFFFFF80, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        tick();
        drive(5'd6, 1'b1, 32'h0, 1'b1, 3'b010, 2'b00, 1'b0, 32'h0, 32'h0);
        ex("lbu_00", 5'd6, 1'b1, 32'h00000080, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        tick();
        drive(5'd8, 1'b1, 32'h0, 1'b1, 3'b001, 2'b10, 1'b0, 32'h0, 32'h0);
        ex("lb_10", 5'd8, 1'b1, 32'h0000007F, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        tick();
        drive(5'd9, 1'b1, 32'h0, 1'b1, 3'b001, 2'b11, 1'b0, 32'h0, 32'h0);
        ex("lb_11", 5'd9, 1'b1, 32'h00000001, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        tick();
        drive(5'd10, 1'b1, 32'h0, 1'b1, 3'b010, 2'b01, 1'b0, 32'h0, 32'h0);
        ex("lbu_01", 5'd10, 1'b1, 32'h000000FF, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        tick();

        ram_rdata = 32'h8001F00F;
        drive(5'd11, 1'b1, 32'h0, 1'b1, 3'b011, 2'b10, 1'b0, 32'h0, 32'h0);
        ex("lh_10", 5'd11, 1'b1, 32'hFFFFF00F, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        tick();
        drive(5'd12, 1'b1, 32'h0, 1'b1, 3'b100, 2'b00, 1'b0, 32'h0, 32'h0);
        ex("lhu_00", 5'd12, 1'b1, 32'h00008001, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        tick();
        drive(5'd13, 1'b1, 32'h0, 1'b1, 3'b011, 2'b01, 1'b0, 32'h0, 32'h0);
        ex("lh_01_misalign", 5'd13, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
        tick();
        drive(5'd14, 1'b1, 32'h0, 1'b1, 3'b111, 2'b10, 1'b0, 32'h0, 32'h0);
        ex("lw_dflt_10_misalign", 5'd14, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
        tick();
        drive(5'd15, 1'b1, 32'h0, 1'b1, 3'b011, 2'b10, 1'b0, 32'h0, 32'h0);
        ex("lh_after_misalign", 5'd15, 1'b1, 32'hFFFFF00F, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        tick();

        // WB stall: the RAM word changes after the first WB cycle
        ram_rdata = 32'hCAFEBABE;
        drive(5'd20, 1'b1, 32'h0, 1'b1, 3'b000, 2'b00, 1'b0, 32'h0, 32'h0);
        ex("lw_enter", 5'd20, 1'b1, 32'hCAFEBABE, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        tick();
        stall = 6'b110000;
        drive(5'd21, 1'b1, 32'h11111111, 1'b0, 3'b000, 2'b00, 1'b0, 32'h0, 32'h0);
        ex("wb_stall_1", 5'd20, 1'b1, 32'hCAFEBABE, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        tick();
        ram_rdata = 32'hDEADBEEF;
        ex("wb_stall_2", 5'd20, 1'b1, 32'hCAFEBABE, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        tick();
        ex("wb_stall_3", 5'd20, 1'b1, 32'hCAFEBABE, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        tick();

        stall = 6'b010000;
        ex("bubble_1", 5'd0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        tick();
        ex("bubble_2", 5'd0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        tick();

        stall = 6'b000000;
        ram_rdata = 32'h11112222;
        drive(5'd22, 1'b1, 32'h0, 1'b1, 3'b000, 2'b00, 1'b0, 32'h0, 32'h0);
        ex("lw_before_flush", 5'd22, 1'b1, 32'h11112222, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        tick();
        stall = 6'b110000;
        ex("lw_hold", 5'd22, 1'b1, 32'h11112222, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        tick();
        flush = 1'b1;
        ram_rdata = 32'h33334444;
        ex("flush_over_stall", 5'd0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        tick();
        stall = 6'b000000;
        ex("flush_over_capture", 5'd0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        tick();
        flush = 1'b0;
        ram_rdata = 32'h55556666;
        drive(5'd23, 1'b1, 32'h0, 1'b1, 3'b100, 2'b10, 1'b0, 32'h0, 32'h0);
        ex("lhu_after_flush", 5'd23, 1'b1, 32'h00006666, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        tick();
        stall = 6'b110000;
        ex("relatch_after_flush", 5'd23, 1'b1, 32'h00006666, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        tick();
        ram_rdata = 32'h0;
        ex("relatch_hold", 5'd23, 1'b1, 32'h00006666, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        tick();

        stall = 6'b000000;
        drive(5'd0, 1'b0, 32'h0, 1'b0, 3'b000, 2'b00, 1'b1, 32'hA, 32'hB);
        ex("hilo", 5'd0, 1'b0, 32'h0, 1'b1, 32'hA, 32'hB, 1'b0, 1'b0);
        tick();

        rst = 1'b0;
        drive(5'd4, 1'b1, 32'h9, 1'b0, 3'b000, 2'b00, 1'b1, 32'h3, 32'h4);
        ex("reset_mid", 5'd0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        tick();

        tick();
        tick();
        while (expq.size() > 0) begin
            exp_t  e;
            string n;
            e = expq.pop_front();
            n = nameq.pop_front();
            checks = checks + 1;
            errors = errors + 1;
            $display("FAIL %s: never compared, due at cycle %0d, now %0d", n, e.cyc, cyc);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
